// File: rtl/axi4_lite_master_if.sv
// axi4_lite_master_if: single-outstanding AXI4-Lite initiator driven by local register commands
`timescale 1ns/1ps
module axi4_lite_master_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 12,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1023
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_write_i,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]                      rsp_resp_o,
    output logic                            timeout_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr_o,
    output logic [2:0]                      m_axi_awprot_o,
    output logic                            m_axi_awvalid_o,
    input  logic                            m_axi_awready_i,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata_o,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb_o,
    output logic                            m_axi_wvalid_o,
    input  logic                            m_axi_wready_i,
    input  logic [1:0]                      m_axi_bresp_i,
    input  logic                            m_axi_bvalid_i,
    output logic                            m_axi_bready_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr_o,
    output logic [2:0]                      m_axi_arprot_o,
    output logic                            m_axi_arvalid_o,
    input  logic                            m_axi_arready_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata_i,
    input  logic [1:0]                      m_axi_rresp_i,
    input  logic                            m_axi_rvalid_i,
    output logic                            m_axi_rready_o
);
    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;
    state_t                            state_q, state_d;
    logic [15:0]                       cnt_q, cnt_d;
    logic                              waiting, hit;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, rdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic [1:0]                        resp_q;
    logic                              awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q, rsp_valid_q, timeout_q;
    assign cmd_ready_o     = state_q == IDLE;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rdata_q;
    assign rsp_resp_o      = resp_q;
    assign timeout_o       = timeout_q;
    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_awprot_o  = 3'b000;
    assign m_axi_arprot_o  = 3'b000;
    assign m_axi_awvalid_o = awvalid_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = wstrb_q;
    assign m_axi_wvalid_o  = wvalid_q;
    assign m_axi_bready_o  = bready_q;
    assign m_axi_arvalid_o = arvalid_q;
    assign m_axi_rready_o  = rready_q;
    // Next state plus the wait counter, which restarts on every state change and saturates
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cmd_valid_i ? (cmd_write_i ? WR : RA) : IDLE;
            WR:      state_d = ((!awvalid_q || m_axi_awready_i) && (!wvalid_q || m_axi_wready_i)) ? WB : WR;
            WB:      state_d = m_axi_bvalid_i ? RSP : WB;
            RA:      state_d = m_axi_arready_i ? RD : RA;
            RD:      state_d = m_axi_rvalid_i ? RSP : RD;
            RSP:     state_d = rsp_ready_i ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
        waiting = state_q inside {WR, WB, RA, RD};
        cnt_d   = (state_d != state_q) ? 16'd0 : (waiting && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        hit     = TIMEOUT_CYCLES != 0 && {16'd0, cnt_d} == 32'(TIMEOUT_CYCLES);
    end
    // Transaction FSM; every bus-facing output is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_q | hit;
            case (state_q)
                IDLE: if (cmd_valid_i) begin
                    addr_q    <= cmd_addr_i;
                    wdata_q   <= cmd_wdata_i;
                    wstrb_q   <= cmd_wstrb_i;
                    awvalid_q <= cmd_write_i;
                    wvalid_q  <= cmd_write_i;
                    arvalid_q <= !cmd_write_i;
                end
                WR: begin
                    awvalid_q <= awvalid_q && !m_axi_awready_i;
                    wvalid_q  <= wvalid_q && !m_axi_wready_i;
                    bready_q  <= state_d == WB;
                end
                WB: if (m_axi_bvalid_i) begin
                    bready_q    <= 1'b0;
                    resp_q      <= m_axi_bresp_i;
                    rdata_q     <= '0;
                    rsp_valid_q <= 1'b1;
                end
                RA: if (m_axi_arready_i) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                end
                RD: if (m_axi_rvalid_i) begin
                    rready_q    <= 1'b0;
                    resp_q      <= m_axi_rresp_i;
                    rdata_q     <= m_axi_rdata_i;
                    rsp_valid_q <= 1'b1;
                end
                RSP: if (rsp_ready_i) rsp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_master_if.sv
// tb_axi4_lite_master_if: directed vector and corner-case bench for the AXI4-Lite initiator
`timescale 1ns/1ps
module tb_axi4_lite_master_if;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
    logic [11:0] cmd_addr = 0;
    logic [31:0] cmd_wdata = 0;
    logic [3:0]  cmd_wstrb = 0;
    logic        cmd_ready, rsp_valid, timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [11:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic [31:0] rdata = 0;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    axi4_lite_master_if #(.C_M_AXI_ADDR_WIDTH(12), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_resp_o(rsp_resp), .timeout_o(timeout),
        .m_axi_awaddr_o(awaddr), .m_axi_awprot_o(awprot), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
        .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
        .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
        .m_axi_araddr_o(araddr), .m_axi_arprot_o(arprot), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
    );

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic offer(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 0; cmd_addr = ~a; cmd_wdata = ~d; cmd_wstrb = ~s;
    endtask

    // Full transaction against a slave that answers every handshake immediately
    task automatic run_tx(input vec_t v, input string tag);
        @(negedge clk);
        chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 1);
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        @(negedge clk);
        cmd_valid = 0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_wstrb = ~v.wstrb;
        chk({tag, "_awvalid"}, 32'(awvalid), 32'(v.wr));
        chk({tag, "_wvalid"}, 32'(wvalid), 32'(v.wr));
        chk({tag, "_arvalid"}, 32'(arvalid), 32'(!v.wr));
        chk({tag, "_cmd_ready_busy1"}, 32'(cmd_ready), 0);
        if (v.wr) begin
            chk({tag, "_awaddr"}, 32'(awaddr), 32'(v.addr));
            chk({tag, "_wdata"}, wdata, v.wdata);
            chk({tag, "_wstrb"}, 32'(wstrb), 32'(v.wstrb));
        end else chk({tag, "_araddr"}, 32'(araddr), 32'(v.addr));
        awready = 1; wready = 1; arready = 1;
        @(negedge clk);
        awready = 0; wready = 0; arready = 0;
        chk({tag, "_valids_low"}, {29'd0, awvalid, wvalid, arvalid}, 0);
        chk({tag, "_bready"}, 32'(bready), 32'(v.wr));
        chk({tag, "_rready"}, 32'(rready), 32'(!v.wr));
        chk({tag, "_cmd_ready_busy2"}, 32'(cmd_ready), 0);
        bvalid = v.wr; rvalid = !v.wr; bresp = v.sresp; rresp = v.sresp; rdata = v.srdata;
        @(negedge clk);
        bvalid = 0; rvalid = 0;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
        chk({tag, "_rsp_resp"}, 32'(rsp_resp), 32'(v.exp_resp));
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_ready_low"}, {30'd0, bready, rready}, 0);
        chk({tag, "_cmd_ready_busy3"}, 32'(cmd_ready), 0);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk({tag, "_rsp_done"}, 32'(rsp_valid), 0);
        chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 12'h100, 32'h0000_0010, 4'hF, 2'b00, 32'hBAD0_BAD0, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 12'h008, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 12'h7FF, 32'hCAFE_F00D, 4'h0, 2'b10, 32'h1111_1111, 2'b10, 32'h0};
        vecs[3] = '{1'b0, 12'hFFF, 32'h0,         4'h0, 2'b11, 32'h1234_5678, 2'b11, 32'h1234_5678};

        repeat (2) @(negedge clk);
        chk("rst_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_resp_timeout", {29'd0, rsp_resp, timeout}, 0);
        chk("rst_addr_data", {8'd0, awaddr, araddr} | wdata, 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("prot", {26'd0, awprot, arprot}, 0);
        rst = 0;

        for (int i = 0; i < 4; i++) run_tx(vecs[i], $sformatf("vec%0d", i));

        // WREADY three cycles ahead of AWREADY
        offer(1'b1, 12'h204, 32'hA5A5_5A5A, 4'h3);
        chk("t2_both_valid", {30'd0, awvalid, wvalid}, 3);
        wready = 1;
        @(negedge clk);
        wready = 0;
        chk("t2_wvalid_drop", 32'(wvalid), 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_awvalid_held%0d", i), 32'(awvalid), 1);
            chk($sformatf("t2_awaddr_stable%0d", i), 32'(awaddr), 32'h204);
            chk($sformatf("t2_no_bready%0d", i), 32'(bready), 0);
            if (i == 2) awready = 1;
            @(negedge clk);
        end
        awready = 0;
        chk("t2_awvalid_drop", 32'(awvalid), 0);
        chk("t2_bready", 32'(bready), 1);
        bvalid = 1; bresp = 2'b01;
        @(negedge clk);
        bvalid = 0;
        chk("t2_rsp_valid", 32'(rsp_valid), 1);
        chk("t2_rsp_resp", 32'(rsp_resp), 1);
        chk("t2_bready_off", 32'(bready), 0);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("t2_single_rsp", 32'(rsp_valid), 0);
        chk("t2_cmd_ready", 32'(cmd_ready), 1);

        // Read with ARREADY held off for four cycles and a one-cycle RVALID delay
        offer(1'b0, 12'h008, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_arvalid%0d", i), 32'(arvalid), 1);
            chk($sformatf("t3_araddr%0d", i), 32'(araddr), 32'h008);
            chk($sformatf("t3_no_rready%0d", i), 32'(rready), 0);
            if (i == 3) arready = 1;
            @(negedge clk);
        end
        arready = 0;
        chk("t3_arvalid_drop", 32'(arvalid), 0);
        chk("t3_rready", 32'(rready), 1);
        @(negedge clk);
        chk("t3_rready_wait", 32'(rready), 1);
        rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        @(negedge clk);
        rvalid = 0; rdata = 0;
        chk("t3_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t3_rready_off", 32'(rready), 0);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("t3_cmd_ready", 32'(cmd_ready), 1);

        // SLVERR read with the local consumer stalling the response
        offer(1'b0, 12'h010, 32'h0, 4'h0);
        arready = 1;
        @(negedge clk);
        arready = 0; rvalid = 1; rdata = 32'h0BAD_F00D; rresp = 2'b10;
        @(negedge clk);
        rvalid = 0; rdata = 0; rresp = 0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t4_rsp_valid%0d", i), 32'(rsp_valid), 1);
            chk($sformatf("t4_rsp_resp%0d", i), 32'(rsp_resp), 2);
            chk($sformatf("t4_rsp_rdata%0d", i), rsp_rdata, 32'h0BAD_F00D);
            chk($sformatf("t4_cmd_ready%0d", i), 32'(cmd_ready), 0);
            if (i == 6) rsp_ready = 1;
            @(negedge clk);
        end
        rsp_ready = 0;
        chk("t4_cmd_ready_back", 32'(cmd_ready), 1);
        chk("t4_rsp_done", 32'(rsp_valid), 0);

        // Write response withheld for 20 cycles against an 8-cycle timeout
        offer(1'b1, 12'h300, 32'h1, 4'hF);
        awready = 1; wready = 1;
        @(negedge clk);
        awready = 0; wready = 0;
        for (int j = 0; j < 20; j++) begin
            chk($sformatf("t5_bready%0d", j), 32'(bready), 1);
            chk($sformatf("t5_timeout%0d", j), 32'(timeout), 32'(j >= 8));
            if (j == 19) begin bvalid = 1; bresp = 2'b00; end
            @(negedge clk);
        end
        bvalid = 0;
        chk("t5_rsp_valid", 32'(rsp_valid), 1);
        chk("t5_rsp_resp", 32'(rsp_resp), 0);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("t5_cmd_ready", 32'(cmd_ready), 1);
        chk("t5_timeout_sticky", 32'(timeout), 1);

        // Asynchronous reset in the middle of a write
        offer(1'b1, 12'h0AC, 32'h5555_AAAA, 4'hF);
        chk("t6_awvalid_before", 32'(awvalid), 1);
        #2 rst = 1;
        #1;
        chk("t6_valids_async", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 0);
        chk("t6_timeout_clr", 32'(timeout), 0);
        chk("t6_awaddr_clr", 32'(awaddr), 0);
        chk("t6_idle", 32'(cmd_ready), 1);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("t6_cmd_ready_after", 32'(cmd_ready), 1);
        chk("t6_rsp_none", 32'(rsp_valid), 0);
        run_tx(vecs[1], "t6_recover");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
